// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR state encoding and fixed-point helpers
package fir_pkg;

    localparam int DEFAULT_FRAC_BITS = 10;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_MAC   = 2'd1,
        ST_WRITE = 2'd2
    } fir_state_e;

    // Truncate a full product to 'width' bits (signed), then divide by 2^frac
    // rounding toward zero; negative values get a bias so the shift truncates
    // toward zero instead of toward minus infinity.
    function automatic logic signed [63:0] dequantize(
        input logic signed [127:0] prod,
        input int unsigned         width,
        input int unsigned         frac
    );
        logic signed [127:0] t;
        logic signed [127:0] bias;
        t    = (prod <<< (128 - width)) >>> (128 - width);
        bias = (128'sd1 <<< frac) - 128'sd1;
        if (t < 0) begin
            t = t + bias;
        end
        return 64'(t >>> frac);
    endfunction

endpackage

// File: rtl/fir_mac_lane.sv
// rtl/fir_mac_lane.sv - combinational multiply/dequantize/sum across one MAC slice
module fir_mac_lane
    import fir_pkg::*;
#(
    parameter int MULT_PER_CYCLE = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int FRAC_BITS      = DEFAULT_FRAC_BITS
) (
    input  logic [MULT_PER_CYCLE-1:0][DATA_WIDTH-1:0] taps,
    input  logic [MULT_PER_CYCLE-1:0][DATA_WIDTH-1:0] samples,
    output logic [DATA_WIDTH-1:0]                     sum
);

    if (DATA_WIDTH > 64) begin : g_width_chk
        $error("fir_mac_lane: DATA_WIDTH must not exceed 64");
    end

    // Each term is dequantized on its own before the wrap-around sum.
    always_comb begin
        logic signed [2*DATA_WIDTH-1:0] prod;
        prod = '0;
        sum  = '0;
        for (int i = 0; i < MULT_PER_CYCLE; i++) begin
            prod = $signed(taps[i]) * $signed(samples[i]);
            sum  = sum + DATA_WIDTH'(dequantize(128'(prod), DATA_WIDTH, FRAC_BITS));
        end
    end

endmodule

// File: rtl/fir_interpolator.sv
// rtl/fir_interpolator.sv - polyphase interpolating FIR with time-multiplexed MAC
module fir_interpolator
    import fir_pkg::*;
#(
    parameter int TAP_COUNT      = 32,
    parameter int INTERP_FACTOR  = 4,
    parameter int MULT_PER_CYCLE = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int FRAC_BITS      = DEFAULT_FRAC_BITS,
    parameter logic [0:TAP_COUNT-1][DATA_WIDTH-1:0] TAPS = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic [DATA_WIDTH-1:0] out_din
);

    localparam int PHASE_TAPS = TAP_COUNT / INTERP_FACTOR;
    localparam int M_CYCLES   = PHASE_TAPS / MULT_PER_CYCLE;
    localparam int PW = (INTERP_FACTOR > 1) ? $clog2(INTERP_FACTOR) : 1;
    localparam int CW = (M_CYCLES > 1)      ? $clog2(M_CYCLES)      : 1;
    localparam int TW = (TAP_COUNT > 1)     ? $clog2(TAP_COUNT)     : 1;
    localparam int XW = (PHASE_TAPS > 1)    ? $clog2(PHASE_TAPS)    : 1;

    if (TAP_COUNT % INTERP_FACTOR != 0) begin : g_tap_chk
        $error("fir_interpolator: TAP_COUNT must be a multiple of INTERP_FACTOR");
    end
    if (PHASE_TAPS % MULT_PER_CYCLE != 0) begin : g_mult_chk
        $error("fir_interpolator: MULT_PER_CYCLE must divide TAP_COUNT/INTERP_FACTOR");
    end

    fir_state_e                            state_q, state_d;
    logic [0:PHASE_TAPS-1][DATA_WIDTH-1:0] x_q, x_d;
    logic [PW-1:0]                         phase_q, phase_d;
    logic [CW-1:0]                         mac_cnt_q, mac_cnt_d;
    logic [DATA_WIDTH-1:0]                 acc_q, acc_d;
    logic [DATA_WIDTH-1:0]                 out_din_q, out_din_d;
    logic                                  rst_hold_q, rst_hold_d;

    logic [MULT_PER_CYCLE-1:0][DATA_WIDTH-1:0] lane_taps;
    logic [MULT_PER_CYCLE-1:0][DATA_WIDTH-1:0] lane_x;
    logic [DATA_WIDTH-1:0]                     lane_sum;

    // Select the taps of the current phase and the matching history samples.
    always_comb begin
        int j;
        j         = 0;
        lane_taps = '0;
        lane_x    = '0;
        for (int i = 0; i < MULT_PER_CYCLE; i++) begin
            j            = int'(mac_cnt_q) * MULT_PER_CYCLE + i;
            lane_x[i]    = x_q[XW'(j)];
            lane_taps[i] = TAPS[TW'(int'(phase_q) + j * INTERP_FACTOR)];
        end
    end

    fir_mac_lane #(
        .MULT_PER_CYCLE (MULT_PER_CYCLE),
        .DATA_WIDTH     (DATA_WIDTH),
        .FRAC_BITS      (FRAC_BITS)
    ) u_lane (
        .taps    (lane_taps),
        .samples (lane_x),
        .sum     (lane_sum)
    );

    // Next-state, datapath updates and FIFO handshakes; the cycle after reset is kept idle.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        phase_d    = phase_q;
        mac_cnt_d  = mac_cnt_q;
        acc_d      = acc_q;
        out_din_d  = out_din_q;
        rst_hold_d = reset;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (!in_empty && !reset && !rst_hold_q) begin
                    in_rd_en = 1'b1;
                    x_d[0]   = in_dout;
                    for (int k = 1; k < PHASE_TAPS; k++) begin
                        x_d[k] = x_q[k-1];
                    end
                    phase_d   = '0;
                    mac_cnt_d = '0;
                    acc_d     = '0;
                    state_d   = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + lane_sum;
                if (mac_cnt_q == CW'(M_CYCLES - 1)) begin
                    mac_cnt_d = '0;
                    out_din_d = acc_d;
                    state_d   = ST_WRITE;
                end else begin
                    mac_cnt_d = mac_cnt_q + CW'(1);
                end
            end
            ST_WRITE: begin
                if (!out_full && !reset) begin
                    out_wr_en = 1'b1;
                    if (phase_q != PW'(INTERP_FACTOR - 1)) begin
                        phase_d = phase_q + PW'(1);
                        acc_d   = '0;
                        state_d = ST_MAC;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        rst_hold_q <= rst_hold_d;
        if (reset) begin
            state_q   <= ST_LOAD;
            x_q       <= '0;
            phase_q   <= '0;
            mac_cnt_q <= '0;
            acc_q     <= '0;
            out_din_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            phase_q   <= phase_d;
            mac_cnt_q <= mac_cnt_d;
            acc_q     <= acc_d;
            out_din_q <= out_din_d;
        end
    end

    assign out_din = out_din_q;

endmodule

// File: tb/tb_fir_interpolator.sv
// tb/tb_fir_interpolator.sv - directed self-checking bench for fir_interpolator
module tb_fir_interpolator;

    localparam int DW = 32;
    localparam int NT = 8;
    localparam logic [0:NT-1][DW-1:0] TAPS_A = {32'd0, 32'd1024, 32'd2048, 32'd3072,
                                                 32'd4096, 32'd5120, 32'd6144, 32'd7168};
    localparam logic [0:NT-1][DW-1:0] TAPS_B = {8{32'd1}};

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_dout_a = '0, in_dout_b = '0;
    logic          in_empty_a = 1'b1, in_empty_b = 1'b1;
    logic          out_full_a = 1'b0, out_full_b = 1'b0;
    logic          in_rd_en_a, in_rd_en_b, out_wr_en_a, out_wr_en_b;
    logic [DW-1:0] out_din_a, out_din_b;

    always #5 clock = ~clock;

    fir_interpolator #(.TAP_COUNT(NT), .INTERP_FACTOR(2), .MULT_PER_CYCLE(2),
                       .DATA_WIDTH(DW), .FRAC_BITS(10), .TAPS(TAPS_A)) dut_a (
        .clock(clock), .reset(reset), .in_dout(in_dout_a), .in_empty(in_empty_a),
        .in_rd_en(in_rd_en_a), .out_full(out_full_a), .out_wr_en(out_wr_en_a),
        .out_din(out_din_a));

    fir_interpolator #(.TAP_COUNT(NT), .INTERP_FACTOR(2), .MULT_PER_CYCLE(2),
                       .DATA_WIDTH(DW), .FRAC_BITS(10), .TAPS(TAPS_B)) dut_b (
        .clock(clock), .reset(reset), .in_dout(in_dout_b), .in_empty(in_empty_b),
        .in_rd_en(in_rd_en_b), .out_full(out_full_b), .out_wr_en(out_wr_en_b),
        .out_din(out_din_b));

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int both   = 0;
    logic [DW-1:0] src_a[$], src_b[$], got_a[$], got_b[$], exp_q[$];
    int            acyc_a[$], wcyc_a[$];
    logic          rst_req = 1'b1, full_a = 1'b0;
    logic          rd_a, wr_a, rd_b, wr_b;
    logic [DW-1:0] held;
    int            ha[NT];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    endtask

    function automatic logic [DW-1:0] qa(input int i);
        return (i < got_a.size()) ? got_a[i] : 'x;
    endfunction

    function automatic logic [DW-1:0] qb(input int i);
        return (i < got_b.size()) ? got_b[i] : 'x;
    endfunction

    function automatic int cq(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1000;
    endfunction

    function automatic int deq(input int h, input int x);
        longint prod;
        int     t;
        prod = longint'(h) * longint'(x);
        t    = int'(prod);
        return t / 1024;
    endfunction

    // One clock: drive inputs on the falling edge, observe handshakes before the rising edge.
    task automatic step();
        @(negedge clock);
        reset      = rst_req;
        in_empty_a = (src_a.size() == 0);
        in_dout_a  = (src_a.size() != 0) ? src_a[0] : '0;
        in_empty_b = (src_b.size() == 0);
        in_dout_b  = (src_b.size() != 0) ? src_b[0] : '0;
        out_full_a = full_a;
        out_full_b = 1'b0;
        #2;
        rd_a = in_rd_en_a; wr_a = out_wr_en_a;
        rd_b = in_rd_en_b; wr_b = out_wr_en_b;
        if (rd_a) begin acyc_a.push_back(cyc); void'(src_a.pop_front()); end
        if (wr_a) begin wcyc_a.push_back(cyc); got_a.push_back(out_din_a); end
        if (rd_b) void'(src_b.pop_front());
        if (wr_b) got_b.push_back(out_din_b);
        if ((rd_a && wr_a) || (rd_b && wr_b)) both++;
        cyc++;
    endtask

    task automatic run_a(input int n, input string tag);
        int k = 0;
        while (got_a.size() < n && k < 1000) begin step(); k++; end
        check(tag, 32'(got_a.size() >= n), 32'd1);
    endtask

    task automatic run_b(input int n, input string tag);
        int k = 0;
        while (got_b.size() < n && k < 1000) begin step(); k++; end
        check(tag, 32'(got_b.size() >= n), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < NT; i++) ha[i] = i * 1024;

        // Reset behaviour, with a sample already waiting upstream.
        src_a.push_back(32'd1);
        step();
        check("rst_rd", 32'(rd_a), 32'd0);
        step();
        check("rst_wr", 32'(wr_a), 32'd0);
        check("rst_dout", out_din_a, 32'd0);
        rst_req = 1'b0;
        step();
        check("post_rst_rd", 32'(rd_a), 32'd0);

        // Impulse response and timing.
        for (int i = 0; i < 5; i++) src_a.push_back(32'd0);
        run_a(12, "imp_done");
        for (int i = 0; i < 12; i++) check($sformatf("imp_%0d", i), qa(i), (i < 8) ? 32'(i) : 32'd0);
        check("latency", 32'(cq(wcyc_a, 0) - cq(acyc_a, 0)), 32'd3);
        check("phase_gap", 32'(cq(wcyc_a, 1) - cq(wcyc_a, 0)), 32'd3);
        check("in_period", 32'(cq(acyc_a, 1) - cq(acyc_a, 0)), 32'd7);

        // Backpressure on phase 1 with another sample waiting upstream.
        got_a.delete();
        src_a.push_back(32'd5);
        run_a(1, "bp_ph0");
        check("bp_ph0_val", qa(0), 32'd0);
        src_a.push_back(32'd7);
        full_a = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            check($sformatf("bp_wr_%0d", k), 32'(wr_a), 32'd0);
            check($sformatf("bp_rd_%0d", k), 32'(rd_a), 32'd0);
            if (k >= 2) check($sformatf("bp_hold_%0d", k), out_din_a, 32'd5);
        end
        held = out_din_a;
        full_a = 1'b0;
        step();
        check("bp_release_wr", 32'(wr_a), 32'd1);
        check("bp_release_val", qa(1), 32'd5);
        check("bp_held_val", held, 32'd5);
        run_a(4, "bp_next");
        check("bp_next0", qa(2), 32'd10);
        check("bp_next1", qa(3), 32'd22);

        // Starvation: stay idle in LOAD, then accept on the first non-empty cycle.
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("starve_rd_%0d", k), 32'(rd_a), 32'd0);
            check($sformatf("starve_wr_%0d", k), 32'(wr_a), 32'd0);
        end
        src_a.push_back(32'd0);
        step();
        check("starve_accept", 32'(rd_a), 32'd1);
        run_a(6, "starve_drain");
        check("starve_out0", qa(4), 32'd34);
        check("starve_out1", qa(5), 32'd46);

        // Reset one cycle into MAC discards the pending phases and the history.
        got_a.delete();
        src_a.push_back(32'd1);
        begin
            int k = 0;
            do begin step(); k++; end while (!rd_a && k < 50);
        end
        check("rm_accept", 32'(rd_a), 32'd1);
        step();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("rm_no_write", 32'(got_a.size()), 32'd0);
        src_a.push_back(32'd1);
        for (int i = 0; i < 3; i++) src_a.push_back(32'd0);
        run_a(8, "rm_imp_done");
        for (int i = 0; i < 8; i++) check($sformatf("rm_imp_%0d", i), qa(i), 32'(i));

        // Rounding toward zero on the all-ones prototype.
        src_b.push_back(-32'sd1023);
        run_b(2, "rnd_a_done");
        check("rnd_m1023_p0", qb(0), 32'd0);
        check("rnd_m1023_p1", qb(1), 32'd0);
        src_b.push_back(-32'sd1024);
        run_b(4, "rnd_b_done");
        check("rnd_m1024_p0", qb(2), 32'hFFFF_FFFF);
        check("rnd_m1024_p1", qb(3), 32'hFFFF_FFFF);

        // Random stream against a polyphase golden model.
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        got_a.delete();
        begin
            int hist[4] = '{0, 0, 0, 0};
            int s;
            for (int n = 0; n < 64; n++) begin
                for (int j = 3; j > 0; j--) hist[j] = hist[j-1];
                hist[0] = int'($urandom);
                src_a.push_back(32'(hist[0]));
                for (int p = 0; p < 2; p++) begin
                    s = 0;
                    for (int j = 0; j < 4; j++) s = s + deq(ha[p + j * 2], hist[j]);
                    exp_q.push_back(32'(s));
                end
            end
        end
        run_a(128, "stream_done");
        check("stream_count", 32'(got_a.size()), 32'd128);
        for (int i = 0; i < 128; i++) check($sformatf("stream_%0d", i), qa(i), exp_q[i]);

        check("rd_wr_exclusive", 32'(both), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
